// File: rtl/index_row_segmenter.sv
// Index buffer between pattern_decoder and the vector-fetch stage: one pending register
// tags the last nonzero of each row, then a fall-through FIFO feeds a valid/ready consumer.
module index_row_segmenter #(
  parameter int INDEX_WIDTH  = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_index_push,
  input  logic [INDEX_WIDTH-1:0]       i_row,
  input  logic [INDEX_WIDTH-1:0]       i_col,
  input  logic                         i_flush,
  output logic                         o_stall,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [INDEX_WIDTH-1:0]       o_out_row,
  output logic [INDEX_WIDTH-1:0]       o_out_col,
  output logic                         o_out_row_end,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_idle
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 * INDEX_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - AFULL_MARGIN);

  logic                   r_pendValid;
  logic [INDEX_WIDTH-1:0] r_pendRow;
  logic [INDEX_WIDTH-1:0] r_pendCol;
  logic                   r_deferFlush;
  logic [EW-1:0]          r_mem [DEPTH];
  logic [PW-1:0]          r_wrPtr;
  logic [PW-1:0]          r_rdPtr;
  logic [CW-1:0]          r_count;
  logic                   r_stall;
  logic                   r_overflow;

  logic                   w_wrEn;
  logic [EW-1:0]          w_wrData;
  logic                   w_pendClear;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_accept;
  logic [EW-1:0]          w_head;

  // A deferred flush commits the entry loaded alongside it, taking priority over the row compare.
  always_comb begin
    w_wrEn      = 1'b0;
    w_wrData    = '0;
    w_pendClear = 1'b0;
    if (r_deferFlush) begin
      w_wrEn      = 1'b1;
      w_wrData    = {1'b1, r_pendRow, r_pendCol};
      w_pendClear = 1'b1;
    end else if (i_index_push && r_pendValid) begin
      w_wrEn   = 1'b1;
      w_wrData = {(r_pendRow != i_row), r_pendRow, r_pendCol};
    end else if (i_flush && !i_index_push && r_pendValid) begin
      w_wrEn      = 1'b1;
      w_wrData    = {1'b1, r_pendRow, r_pendCol};
      w_pendClear = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pendValid  <= 1'b0;
      r_pendRow    <= '0;
      r_pendCol    <= '0;
      r_deferFlush <= 1'b0;
    end else begin
      r_deferFlush <= i_index_push && i_flush;
      if (i_index_push) begin
        r_pendValid <= 1'b1;
        r_pendRow   <= i_row;
        r_pendCol   <= i_col;
      end else if (w_pendClear) begin
        r_pendValid <= 1'b0;
      end
    end
  end

  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = (r_count != '0) && i_out_ready;
  assign w_accept = w_wrEn && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wrPtr] <= w_wrData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      // Stall follows occupancy one cycle late; the margin absorbs that lag.
      r_stall <= (r_count >= STALL_CNT);
      if (w_wrEn && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head        = r_mem[r_rdPtr];
  assign o_out_valid   = (r_count != '0);
  assign o_out_row_end = o_out_valid ? w_head[EW-1] : 1'b0;
  assign o_out_row     = o_out_valid ? w_head[2*INDEX_WIDTH-1:INDEX_WIDTH] : '0;
  assign o_out_col     = o_out_valid ? w_head[INDEX_WIDTH-1:0] : '0;
  assign o_count       = r_count;
  assign o_stall       = r_stall;
  assign o_overflow    = r_overflow;
  assign o_idle        = !r_pendValid && (r_count == '0) && !r_deferFlush;

endmodule
